// File: rtl/regfile_banked.sv
// Banked register file: one write port, two combinational read ports,
// in-place INC/DEC with a wrap flag, and switchable register banks.
module regfile_banked #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int NUM_BANKS  = 2,
  parameter bit BYPASS     = 1'b0,
  localparam int SW = (NUM_REGS  > 2) ? $clog2(NUM_REGS)  : 1,
  localparam int BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            op,
  input  logic [SW-1:0]         reg_in_sel,
  input  logic [SW-1:0]         reg_1_out_sel,
  input  logic [SW-1:0]         reg_2_out_sel,
  input  logic [DATA_WIDTH-1:0] reg_data_in,
  output logic [DATA_WIDTH-1:0] reg_1_out,
  output logic [DATA_WIDTH-1:0] reg_2_out,
  output logic [BW-1:0]         bank,
  output logic                  wrap
);

  localparam logic [2:0] OP_WRITE    = 3'd1;
  localparam logic [2:0] OP_INC      = 3'd2;
  localparam logic [2:0] OP_DEC      = 3'd3;
  localparam logic [2:0] OP_BANK_SEL = 3'd4;

  logic [DATA_WIDTH-1:0] regs [NUM_BANKS][NUM_REGS];

  logic                  in_ok;
  logic                  is_wr;
  logic                  is_step;
  logic                  upd;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] new_val;
  logic [BW-1:0]         new_bank;
  logic                  bank_ok;

  always_comb begin
    in_ok    = (32'(reg_in_sel) < NUM_REGS);
    is_wr    = (op == OP_WRITE);
    is_step  = (op == OP_INC) || (op == OP_DEC);
    upd      = (is_wr || is_step) && in_ok;
    new_bank = reg_data_in[BW-1:0];
    bank_ok  = (32'(new_bank) < NUM_BANKS);

    old_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reg_in_sel == SW'(r)) old_val = regs[bank][r];
    end

    if (is_wr)
      new_val = reg_data_in;
    else if (op == OP_INC)
      new_val = old_val + DATA_WIDTH'(1);
    else
      new_val = old_val - DATA_WIDTH'(1);
  end

  // Out-of-range selects match no register and therefore read as zero.
  always_comb begin
    reg_1_out = '0;
    reg_2_out = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reg_1_out_sel == SW'(r)) reg_1_out = regs[bank][r];
      if (reg_2_out_sel == SW'(r)) reg_2_out = regs[bank][r];
    end
    if (BYPASS && upd) begin
      if (reg_1_out_sel == reg_in_sel) reg_1_out = new_val;
      if (reg_2_out_sel == reg_in_sel) reg_2_out = new_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < NUM_REGS; r++)
          regs[b][r] <= '0;
      bank <= '0;
      wrap <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (upd && (reg_in_sel == SW'(r))) regs[bank][r] <= new_val;
      end
      // Wrap reflects the old value: all ones before INC, zero before DEC.
      if (is_step && in_ok)
        wrap <= (op == OP_INC) ? (&old_val) : ~(|old_val);
      if ((op == OP_BANK_SEL) && bank_ok)
        bank <= new_bank;
    end
  end

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench: dut a uses the default 4x2 configuration without bypass,
// dut b uses 3 registers, 3 banks and bypass to reach the odd-size cases.
module tb_regfile_banked;

  logic       clock = 1'b0;
  logic       reset = 1'b0;

  logic [2:0] a_op = 3'd0;
  logic [1:0] a_in_sel = 2'd0, a_sel1 = 2'd0, a_sel2 = 2'd0;
  logic [7:0] a_data = 8'd0;
  logic [7:0] a_out1, a_out2;
  logic       a_bank;
  logic       a_wrap;

  logic [2:0] b_op = 3'd0;
  logic [1:0] b_in_sel = 2'd0, b_sel1 = 2'd0, b_sel2 = 2'd0;
  logic [7:0] b_data = 8'd0;
  logic [7:0] b_out1, b_out2;
  logic [1:0] b_bank;
  logic       b_wrap;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_banked u_a (
    .clock(clock), .reset(reset), .op(a_op), .reg_in_sel(a_in_sel),
    .reg_1_out_sel(a_sel1), .reg_2_out_sel(a_sel2), .reg_data_in(a_data),
    .reg_1_out(a_out1), .reg_2_out(a_out2), .bank(a_bank), .wrap(a_wrap)
  );

  regfile_banked #(.DATA_WIDTH(8), .NUM_REGS(3), .NUM_BANKS(3), .BYPASS(1'b1)) u_b (
    .clock(clock), .reset(reset), .op(b_op), .reg_in_sel(b_in_sel),
    .reg_1_out_sel(b_sel1), .reg_2_out_sel(b_sel2), .reg_data_in(b_data),
    .reg_1_out(b_out1), .reg_2_out(b_out2), .bank(b_bank), .wrap(b_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    a_op = 3'd0;
    b_op = 3'd0;
  endtask

  task automatic a_set(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] data);
    a_op = op; a_in_sel = sel; a_data = data;
  endtask

  task automatic b_set(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] data);
    b_op = op; b_in_sel = sel; b_data = data;
  endtask

  task automatic a_read(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    a_sel1 = sel; a_sel2 = sel;
    #1;
    check({tag, "_p1"}, a_out1, exp);
    check({tag, "_p2"}, a_out2, exp);
  endtask

  task automatic b_read(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    b_sel1 = sel; b_sel2 = sel;
    #1;
    check({tag, "_p1"}, b_out1, exp);
    check({tag, "_p2"}, b_out2, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #22 reset = 1'b1;
    tick();

    // Reset state
    for (int s = 0; s < 4; s++) a_read($sformatf("a_rst_r%0d", s), 2'(s), 8'h00);
    for (int s = 0; s < 4; s++) b_read($sformatf("b_rst_r%0d", s), 2'(s), 8'h00);
    check("a_rst_bank", a_bank, 0);
    check("a_rst_wrap", a_wrap, 0);
    check("b_rst_bank", b_bank, 0);
    check("b_rst_wrap", b_wrap, 0);

    // Reset asserted across the edge of a WRITE loses the write
    a_set(3'd1, 2'd2, 8'hA5);
    #2 reset = 1'b0;
    @(posedge clock);
    #1 a_op = 3'd0;
    reset = 1'b1;
    a_read("a_rst_mid_write", 2'd2, 8'h00);
    tick();

    // Write then read; same-cycle read shows old value without bypass
    a_set(3'd1, 2'd2, 8'hA5);
    a_read("a_wr_same_cycle", 2'd2, 8'h00);
    tick();
    a_read("a_wr_next_cycle", 2'd2, 8'hA5);

    b_set(3'd1, 2'd2, 8'hA5);
    b_read("b_wr_bypass", 2'd2, 8'hA5);
    tick();
    b_read("b_wr_next_cycle", 2'd2, 8'hA5);

    // Increment / decrement wrap sequence on a.r1
    a_set(3'd1, 2'd1, 8'hFF); tick();
    a_read("a_r1_ff", 2'd1, 8'hFF);
    check("a_wrap_after_write", a_wrap, 0);
    a_set(3'd2, 2'd1, 8'h00); tick();
    a_read("a_inc_wrap_val", 2'd1, 8'h00);
    check("a_inc_wrap_flag", a_wrap, 1);
    a_set(3'd2, 2'd1, 8'h00); tick();
    a_read("a_inc_val", 2'd1, 8'h01);
    check("a_inc_flag", a_wrap, 0);
    a_set(3'd3, 2'd1, 8'h00); tick();
    a_read("a_dec_val", 2'd1, 8'h00);
    check("a_dec_flag", a_wrap, 0);
    a_set(3'd3, 2'd1, 8'h00); tick();
    a_read("a_dec_wrap_val", 2'd1, 8'hFF);
    check("a_dec_wrap_flag", a_wrap, 1);
    a_set(3'd1, 2'd3, 8'h10); tick();
    check("a_wrap_held_by_write", a_wrap, 1);
    a_read("a_r3", 2'd3, 8'h10);

    // Bank switching keeps each bank's contents
    a_set(3'd1, 2'd0, 8'h11); tick();
    a_set(3'd4, 2'd0, 8'h01);
    a_read("a_bank_sel_same_cycle", 2'd0, 8'h11);
    tick();
    check("a_bank_1", a_bank, 1);
    a_read("a_b1_r0_empty", 2'd0, 8'h00);
    a_read("a_b1_r1_empty", 2'd1, 8'h00);
    a_set(3'd1, 2'd0, 8'h22); tick();
    a_read("a_b1_r0", 2'd0, 8'h22);
    a_set(3'd4, 2'd0, 8'h00);
    a_read("a_bank_sel0_same_cycle", 2'd0, 8'h22);
    tick();
    check("a_bank_0", a_bank, 0);
    a_read("a_b0_r0", 2'd0, 8'h11);
    a_read("a_b0_r1", 2'd1, 8'hFF);
    a_read("a_b0_r2", 2'd2, 8'hA5);
    a_set(3'd4, 2'd0, 8'h01); tick();
    a_read("a_b1_r0_again", 2'd0, 8'h22);
    a_set(3'd4, 2'd0, 8'h03); tick();
    check("a_bank_sel_03", a_bank, 1);
    check("a_wrap_after_bank_sel", a_wrap, 1);

    // Reserved op changes nothing
    a_set(3'd7, 2'd0, 8'h99); tick();
    a_read("a_rsvd_r0", 2'd0, 8'h22);
    check("a_rsvd_bank", a_bank, 1);
    check("a_rsvd_wrap", a_wrap, 1);

    // Out-of-range select on 3-register instance
    b_set(3'd1, 2'd3, 8'h5A);
    b_read("b_oor_same_cycle", 2'd3, 8'h00);
    tick();
    b_read("b_oor_r3", 2'd3, 8'h00);
    b_read("b_oor_r0", 2'd0, 8'h00);
    b_read("b_oor_r1", 2'd1, 8'h00);
    b_read("b_oor_r2", 2'd2, 8'hA5);

    b_set(3'd3, 2'd0, 8'h00);
    b_read("b_dec_bypass", 2'd0, 8'hFF);
    tick();
    check("b_dec_wrap", b_wrap, 1);
    b_set(3'd2, 2'd3, 8'h00); tick();
    check("b_oor_inc_wrap_held", b_wrap, 1);
    b_read("b_oor_inc_r0", 2'd0, 8'hFF);

    // Bank select range check with three banks
    b_set(3'd4, 2'd0, 8'h02); tick();
    check("b_bank_2", b_bank, 2);
    b_set(3'd4, 2'd0, 8'h03); tick();
    check("b_bank_sel_3_ignored", b_bank, 2);
    b_set(3'd4, 2'd0, 8'h07); tick();
    check("b_bank_sel_7_ignored", b_bank, 2);
    b_read("b_b2_r0", 2'd0, 8'h00);

    b_set(3'd7, 2'd0, 8'h33); tick();
    b_read("b_rsvd7_r0", 2'd0, 8'h00);
    check("b_rsvd7_bank", b_bank, 2);
    check("b_rsvd7_wrap", b_wrap, 1);
    b_set(3'd5, 2'd1, 8'h44); tick();
    b_read("b_rsvd5_r1", 2'd1, 8'h00);

    b_sel1 = 2'd1; b_sel2 = 2'd0;
    b_set(3'd2, 2'd1, 8'h00);
    #1;
    check("b_inc_bypass_p1", b_out1, 8'h01);
    check("b_inc_other_p2", b_out2, 8'h00);
    tick();
    check("b_inc_wrap_clear", b_wrap, 0);
    b_read("b_b2_r1", 2'd1, 8'h01);

    b_set(3'd4, 2'd0, 8'h00); tick();
    b_read("b_b0_r0_kept", 2'd0, 8'hFF);
    b_read("b_b0_r2_kept", 2'd2, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
